// File: rtl/score_keeper_if.sv
// Score interface between score_keeper and the score renderer: glyph position
// plus a scaled digit bitmap for each side.
package score_pkg;
  localparam int X_POS_W = 10;
  localparam int Y_POS_W = 10;
  localparam int SCORE_W = 6;
  localparam int SCORE_H = 10;

  typedef struct packed {
    logic [X_POS_W-1:0]                x_pos;
    logic [Y_POS_W-1:0]                y_pos;
    logic [SCORE_H-1:0][SCORE_W-1:0]   score_val;
  } score_t;
endpackage

interface score_if;
  import score_pkg::*;
  score_t player;
  score_t enemy;
  modport score_mp  (output player, output enemy);
  modport render_mp (input player, input enemy);
endinterface

// File: rtl/score_keeper.sv
// Match score keeper: goal counters, serve-hold / game-over FSM and
// frame-synchronous glyph publishing for the score renderer.
//
// state | meaning
// PLAY  | ball in play, goals counted
// HOLD  | ball frozen for HOLD_FRAMES frames after a goal or new game
// OVER  | a side reached WIN_SCORE, winner latched
module score_keeper
  import score_pkg::*;
#(
  parameter int                 WIN_SCORE   = 9,
  parameter int                 HOLD_FRAMES = 60,
  parameter logic [X_POS_W-1:0] PLAYER_X    = 200,
  parameter logic [X_POS_W-1:0] ENEMY_X     = 424,
  parameter logic [Y_POS_W-1:0] SCORE_Y     = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_end_i,
  input  logic       player_goal_i,
  input  logic       enemy_goal_i,
  input  logic       new_game_i,
  output logic       serve_en_o,
  output logic       game_over_o,
  output logic       winner_o,
  output logic [3:0] player_cnt_o,
  output logic [3:0] enemy_cnt_o,
  score_if.score_mp  score_o
);

  localparam int SX = SCORE_W / 3;
  localparam int SY = SCORE_H / 5;

  if ((SCORE_W % 3) != 0 || (SCORE_H % 5) != 0) begin : g_bad_scale
    $error("score_keeper: glyph size must be an integer multiple of the 3x5 font");
  end

  typedef enum logic [1:0] {ST_PLAY, ST_HOLD, ST_OVER} state_t;
  typedef logic [SCORE_H-1:0][SCORE_W-1:0] glyph_t;

  // Row encoding {left, middle, right}; rows packed top-first.
  function automatic logic [2:0] font_row(input logic [3:0] digit, input int row);
    logic [14:0] g;
    case (digit)
      4'd0:    g = 15'b111_101_101_101_111;
      4'd1:    g = 15'b010_110_010_010_111;
      4'd2:    g = 15'b111_001_111_100_111;
      4'd3:    g = 15'b111_001_111_001_111;
      4'd4:    g = 15'b101_101_111_001_001;
      4'd5:    g = 15'b111_100_111_001_111;
      4'd6:    g = 15'b111_100_111_101_111;
      4'd7:    g = 15'b111_001_001_001_001;
      4'd8:    g = 15'b111_101_111_101_111;
      4'd9:    g = 15'b111_101_111_001_111;
      default: g = '0;
    endcase
    return g[14 - 3*row -: 3];
  endfunction

  // Column bit 0 of score_val is the leftmost pixel, hence the 2 - col flip.
  function automatic glyph_t make_glyph(input logic [3:0] digit);
    glyph_t     g;
    logic [2:0] row_bits;
    g = '0;
    for (int r = 0; r < SCORE_H; r++) begin
      row_bits = font_row(digit, r / SY);
      for (int c = 0; c < SCORE_W; c++) begin
        g[r][c] = row_bits[2 - c / SX];
      end
    end
    return g;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] pcnt_q, pcnt_d, ecnt_q, ecnt_d;
  logic [3:0] p_next, e_next;
  logic       winner_q, winner_d;
  glyph_t     pglyph_q, eglyph_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_PLAY;
      hold_q   <= '0;
      pcnt_q   <= '0;
      ecnt_q   <= '0;
      winner_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      pcnt_q   <= pcnt_d;
      ecnt_q   <= ecnt_d;
      winner_q <= winner_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    pcnt_d   = pcnt_q;
    ecnt_d   = ecnt_q;
    winner_d = winner_q;
    p_next   = (pcnt_q == 4'd9) ? pcnt_q : pcnt_q + 4'd1;
    e_next   = (ecnt_q == 4'd9) ? ecnt_q : ecnt_q + 4'd1;

    if (new_game_i) begin
      state_d  = ST_HOLD;
      hold_d   = '0;
      pcnt_d   = '0;
      ecnt_d   = '0;
      winner_d = 1'b0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (player_goal_i || enemy_goal_i) begin
            if (player_goal_i) pcnt_d = p_next;
            if (enemy_goal_i)  ecnt_d = e_next;
            // Simultaneous winning goals resolve in the player's favour.
            if (player_goal_i && p_next == 4'(WIN_SCORE)) begin
              state_d  = ST_OVER;
              winner_d = 1'b1;
            end else if (enemy_goal_i && e_next == 4'(WIN_SCORE)) begin
              state_d  = ST_OVER;
              winner_d = 1'b0;
            end else begin
              state_d = ST_HOLD;
              hold_d  = '0;
            end
          end
        end
        ST_HOLD: begin
          if (frame_end_i) begin
            hold_d = hold_q + 8'd1;
            if (hold_d == 8'(HOLD_FRAMES)) state_d = ST_PLAY;
          end
        end
        ST_OVER: ;
        default: state_d = ST_PLAY;
      endcase
    end
  end

  // Sampling on the frame_end edge itself means a coincident goal is not yet visible.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pglyph_q <= make_glyph(4'd0);
      eglyph_q <= make_glyph(4'd0);
    end else if (frame_end_i) begin
      pglyph_q <= make_glyph(pcnt_q);
      eglyph_q <= make_glyph(ecnt_q);
    end
  end

  assign serve_en_o   = (state_q == ST_PLAY);
  assign game_over_o  = (state_q == ST_OVER);
  assign winner_o     = winner_q;
  assign player_cnt_o = pcnt_q;
  assign enemy_cnt_o  = ecnt_q;

  assign score_o.player = {PLAYER_X, SCORE_Y, pglyph_q};
  assign score_o.enemy  = {ENEMY_X, SCORE_Y, eglyph_q};

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: scoring, hold timing, win handling,
// new-game restart and asynchronous reset, checked against hand-built glyphs.
module tb_score_keeper;
  import score_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       frame_end_i = 1'b0;
  logic       player_goal_i = 1'b0;
  logic       enemy_goal_i = 1'b0;
  logic       new_game_i = 1'b0;
  logic       serve_en_o, game_over_o, winner_o;
  logic [3:0] player_cnt_o, enemy_cnt_o;

  score_if u_if ();

  score_keeper #(
    .WIN_SCORE  (9),
    .HOLD_FRAMES(3),
    .PLAYER_X   (10'd200),
    .ENEMY_X    (10'd424),
    .SCORE_Y    (10'd32)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .frame_end_i  (frame_end_i),
    .player_goal_i(player_goal_i),
    .enemy_goal_i (enemy_goal_i),
    .new_game_i   (new_game_i),
    .serve_en_o   (serve_en_o),
    .game_over_o  (game_over_o),
    .winner_o     (winner_o),
    .player_cnt_o (player_cnt_o),
    .enemy_cnt_o  (enemy_cnt_o),
    .score_o      (u_if.score_mp)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected bitmap: font rows packed bottom-first, bit 0 of each row = left column.
  function automatic logic [63:0] glyph(input int d);
    logic [14:0] f;
    logic [63:0] g;
    case (d)
      0:       f = 15'b111_101_101_101_111;
      1:       f = 15'b111_010_010_011_010;
      8:       f = 15'b111_101_111_101_111;
      9:       f = 15'b111_100_111_101_111;
      default: f = '0;
    endcase
    g = '0;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 6; c++)
        g[r*6 + c] = f[3*(r/2) + c/2];
    return g;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic frame();
    frame_end_i = 1'b1;
    tick();
    frame_end_i = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic goal(input logic p, input logic e);
    player_goal_i = p;
    enemy_goal_i  = e;
    tick();
    player_goal_i = 1'b0;
    enemy_goal_i  = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_pcnt",   player_cnt_o, 0);
    check("rst_ecnt",   enemy_cnt_o, 0);
    check("rst_serve",  serve_en_o, 1);
    check("rst_over",   game_over_o, 0);
    check("rst_winner", winner_o, 0);
    check("rst_px",     u_if.player.x_pos, 200);
    check("rst_ex",     u_if.enemy.x_pos, 424);
    check("rst_y",      u_if.enemy.y_pos, 32);
    check("rst_pglyph", u_if.player.score_val, glyph(0));

    frames(3);
    check("idle_pglyph", u_if.player.score_val, glyph(0));
    check("idle_eglyph", u_if.enemy.score_val, glyph(0));
    check("idle_serve",  serve_en_o, 1);
    check("idle_over",   game_over_o, 0);

    goal(1'b1, 1'b0);
    check("goal1_pcnt",  player_cnt_o, 1);
    check("goal1_serve", serve_en_o, 0);
    check("goal1_unpub", u_if.player.score_val, glyph(0));
    frame();
    check("goal1_pub",   u_if.player.score_val, glyph(1));
    goal(1'b1, 1'b0);
    check("hold_goal_ignored", player_cnt_o, 1);
    frame();
    check("hold_serve2", serve_en_o, 0);
    frame();
    check("hold_done_serve", serve_en_o, 1);

    frame_end_i  = 1'b1;
    enemy_goal_i = 1'b1;
    tick();
    frame_end_i  = 1'b0;
    enemy_goal_i = 1'b0;
    check("coinc_ecnt",  enemy_cnt_o, 1);
    check("coinc_glyph", u_if.enemy.score_val, glyph(0));
    frames(3);
    check("coinc_next_glyph", u_if.enemy.score_val, glyph(1));
    check("coinc_serve", serve_en_o, 1);

    for (int k = 2; k <= 8; k++) begin
      goal(1'b1, 1'b0);
      frames(3);
      goal(1'b0, 1'b1);
      frames(3);
    end
    check("pre_pcnt",   player_cnt_o, 8);
    check("pre_ecnt",   enemy_cnt_o, 8);
    check("pre_pglyph", u_if.player.score_val, glyph(8));

    goal(1'b1, 1'b1);
    check("tie_pcnt",   player_cnt_o, 9);
    check("tie_ecnt",   enemy_cnt_o, 9);
    check("tie_over",   game_over_o, 1);
    check("tie_winner", winner_o, 1);
    check("tie_serve",  serve_en_o, 0);
    goal(1'b1, 1'b0);
    goal(1'b0, 1'b1);
    check("over_pcnt_frozen", player_cnt_o, 9);
    check("over_ecnt_frozen", enemy_cnt_o, 9);
    frame();
    check("over_eglyph", u_if.enemy.score_val, glyph(9));
    check("over_stays",  game_over_o, 1);

    new_game_i   = 1'b1;
    enemy_goal_i = 1'b1;
    tick();
    new_game_i   = 1'b0;
    enemy_goal_i = 1'b0;
    check("ng_pcnt",  player_cnt_o, 0);
    check("ng_ecnt",  enemy_cnt_o, 0);
    check("ng_over",  game_over_o, 0);
    check("ng_serve", serve_en_o, 0);
    check("ng_unpub", u_if.player.score_val, glyph(9));
    frame();
    check("ng_pglyph", u_if.player.score_val, glyph(0));
    check("ng_eglyph", u_if.enemy.score_val, glyph(0));
    frames(2);
    check("ng_serve_back", serve_en_o, 1);

    for (int k = 1; k <= 8; k++) begin
      goal(1'b0, 1'b1);
      frames(3);
    end
    goal(1'b0, 1'b1);
    check("ewin_ecnt",   enemy_cnt_o, 9);
    check("ewin_over",   game_over_o, 1);
    check("ewin_winner", winner_o, 0);

    new_game_i = 1'b1;
    tick();
    new_game_i = 1'b0;
    frames(3);
    goal(1'b1, 1'b0); frames(3);
    goal(1'b0, 1'b1); frames(3);
    goal(1'b1, 1'b0); frames(3);
    goal(1'b0, 1'b1); frames(3);
    goal(1'b1, 1'b0); frames(3);
    goal(1'b1, 1'b0);
    frame();
    check("mid_hold_pcnt",  player_cnt_o, 4);
    check("mid_hold_ecnt",  enemy_cnt_o, 2);
    check("mid_hold_serve", serve_en_o, 0);

    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #2;
    check("arst_pcnt",   player_cnt_o, 0);
    check("arst_ecnt",   enemy_cnt_o, 0);
    check("arst_serve",  serve_en_o, 1);
    check("arst_over",   game_over_o, 0);
    check("arst_pglyph", u_if.player.score_val, glyph(0));
    check("arst_px",     u_if.player.x_pos, 200);
    tick();
    rst_i = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
